io_controller: RTL and testbench
================================

IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset; sampled on Clk rising edge only.
REQ-003 SHALL have port Dev_In_Valid, input, 1, input device presents a character.
REQ-004 SHALL have port Dev_In_Data, input, 8, input device character.
REQ-005 SHALL have port Dev_In_Ready, output, 1, controller can accept a character; transfer when Valid&Ready high at same edge.
REQ-006 SHALL have port Dev_Out_Valid, output, 1, character pending to output device.
REQ-007 SHALL have port Dev_Out_Data, output, 8, character to output device.
REQ-008 SHALL have port Dev_Out_Ready, input, 1, output device accepts; transfer when Valid&Ready high at same edge.
REQ-009 SHALL have port INPR, output, 8, input register driven toward AC[7:0].
REQ-010 SHALL have port OUTR_In, input, 8, AC[7:0] value for OUT instruction.
REQ-011 SHALL have port LD_OUTR, input, 1, control-unit strobe executing OUT.
REQ-012 SHALL have port Clear_FGI, input, 1, control-unit strobe executing INP.
REQ-013 SHALL have port IEN, input, 1, interrupt enable flag.
REQ-014 SHALL have ports FGI and FGO, output, 1 each, input/output flags.
REQ-015 SHALL have port IRQ, output, 1, interrupt request to control unit.
REQ-016 SHALL have port Out_Err, output, 1, sticky error: LD_OUTR while FGO=0.

Function
REQ-017 Input FSM SHALL have states IN_EMPTY and IN_FULL; FGI=1 exactly in IN_FULL.
REQ-018 In IN_EMPTY, Dev_In_Ready SHALL be 1; on Dev_In_Valid, INPR SHALL load Dev_In_Data and FSM SHALL enter IN_FULL at same edge (FGI visible next cycle).
REQ-019 In IN_FULL, Dev_In_Ready SHALL be 0 and INPR SHALL hold; Clear_FGI SHALL return FSM to IN_EMPTY at next edge.
REQ-020 Clear_FGI in IN_EMPTY SHALL be ignored.
REQ-021 Output FSM SHALL have states OUT_IDLE (FGO=1) and OUT_SEND (FGO=0); Dev_Out_Valid=1 exactly in OUT_SEND.
REQ-022 LD_OUTR in OUT_IDLE SHALL latch OUTR_In into Dev_Out_Data and enter OUT_SEND at next edge.
REQ-023 In OUT_SEND, Dev_Out_Data SHALL be stable until Dev_Out_Ready; transfer SHALL return FSM to OUT_IDLE (FGO=1 next cycle); minimum OUT round trip 2 cycles.
REQ-024 LD_OUTR in OUT_SEND SHALL be discarded, Dev_Out_Data unchanged, Out_Err set at next edge and held until reset.
REQ-025 IRQ SHALL be registered: IRQ = IEN & (FGI | FGO) of the current cycle, visible one cycle later.
REQ-026 Input and output FSMs SHALL operate independently; simultaneous Clear_FGI, LD_OUTR and device transfers SHALL all take effect in the same edge.

Reset
REQ-027 With Reset=0 at an edge: input FSM IN_EMPTY, INPR=0x00, FGI=0; output FSM OUT_IDLE, FGO=1, Dev_Out_Data=0x00, Dev_Out_Valid=0; Out_Err=0; IRQ=0.
REQ-028 Dev_In_Ready SHALL be 0 while Reset=0; transfers in progress SHALL be abandoned without handshake completion.

Configuration
REQ-029 Macro IO_INBUF_EN SHALL, when defined, add one 8-bit holding entry behind INPR (2-entry input FIFO).
REQ-030 With IO_INBUF_EN: Dev_In_Ready=1 unless both entries full; Clear_FGI with holding entry valid SHALL move it into INPR and keep FGI=1; accept and Clear_FGI in the same cycle SHALL preserve order with no loss.
REQ-031 Without IO_INBUF_EN: behaviour exactly per REQ-017..REQ-020; no holding register synthesised.

Verification
REQ-032 Reset released, Dev_In_Valid=1, Data=0x41 -> next cycle INPR=0x41, FGI=1, Dev_In_Ready=0; Clear_FGI pulse -> FGI=0, Ready=1 next cycle.
REQ-033 LD_OUTR with OUTR_In=0x5A, Dev_Out_Ready=0 for 5 cycles then 1 -> Dev_Out_Valid high 6 cycles, Data=0x5A throughout, FGO=1 after transfer.
REQ-034 Second LD_OUTR (0x33) during OUT_SEND -> Dev_Out_Data stays 0x5A, Out_Err=1 until Reset=0.
REQ-035 IEN=1, reset state (FGO=1) -> IRQ=1 one cycle after reset release; IEN=0 -> IRQ=0 next cycle.
REQ-036 Reset=0 asserted during OUT_SEND and IN_FULL -> next cycle FGO=1, FGI=0, Dev_Out_Valid=0, INPR=0x00.
REQ-037 With IO_INBUF_EN: send 0x01,0x02,0x03 back-to-back -> Ready drops after 0x02; each Clear_FGI presents 0x02 then 0x03 in INPR in order.

Source files
------------

// File: rtl/io_controller_if.sv
// Handshake and control-unit bundle for io_controller.
// Each device link transfers a character when Valid and Ready are both high at the same rising edge.
interface io_controller_if;
    logic       Dev_In_Valid;
    logic [7:0] Dev_In_Data;
    logic       Dev_In_Ready;
    logic       Dev_Out_Valid;
    logic [7:0] Dev_Out_Data;
    logic       Dev_Out_Ready;
    logic [7:0] INPR;
    logic [7:0] OUTR_In;
    logic       LD_OUTR;
    logic       Clear_FGI;
    logic       IEN;
    logic       FGI;
    logic       FGO;
    logic       IRQ;
    logic       Out_Err;
    logic       in_state_dbg;
    logic       out_state_dbg;

    modport slave (
        input  Dev_In_Valid, Dev_In_Data, Dev_Out_Ready, OUTR_In, LD_OUTR, Clear_FGI, IEN,
        output Dev_In_Ready, Dev_Out_Valid, Dev_Out_Data, INPR, FGI, FGO, IRQ, Out_Err,
               in_state_dbg, out_state_dbg
    );

    modport master (
        output Dev_In_Valid, Dev_In_Data, Dev_Out_Ready, OUTR_In, LD_OUTR, Clear_FGI, IEN,
        input  Dev_In_Ready, Dev_Out_Valid, Dev_Out_Data, INPR, FGI, FGO, IRQ, Out_Err,
               in_state_dbg, out_state_dbg
    );
endinterface

// File: rtl/io_controller.sv
// Character I/O controller with FGI/FGO flags, a registered interrupt request and a sticky output error.
// Define IO_INBUF_EN to add a one-entry holding buffer behind INPR (2-entry input FIFO).
module io_controller (
    input  logic            Clk,
    input  logic            Reset,
    io_controller_if.slave  io
);
    typedef enum logic {IN_EMPTY = 1'b0, IN_FULL = 1'b1} in_state_e;
    typedef enum logic {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_e;

    in_state_e  in_state_q, in_state_d;
    out_state_e out_state_q, out_state_d;
    logic [7:0] inpr_q, inpr_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_err_q, out_err_d;
    logic       irq_q, irq_d;
    logic       in_accept;
    logic       fgi;
    logic       fgo;

`ifdef IO_INBUF_EN
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_q, hold_d;

    // The holding entry is only ever occupied while INPR is full.
    assign io.Dev_In_Ready = Reset && !((in_state_q == IN_FULL) && hold_valid_q);
`else
    assign io.Dev_In_Ready = Reset && (in_state_q == IN_EMPTY);
`endif

    assign in_accept = io.Dev_In_Valid && io.Dev_In_Ready;
    assign fgi       = (in_state_q == IN_FULL);
    assign fgo       = (out_state_q == OUT_IDLE);

    always_comb begin
        in_state_d = in_state_q;
        inpr_d     = inpr_q;
`ifdef IO_INBUF_EN
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
`endif
        case (in_state_q)
            IN_EMPTY: begin
                if (in_accept) begin
                    inpr_d     = io.Dev_In_Data;
                    in_state_d = IN_FULL;
                end
            end
            IN_FULL: begin
`ifdef IO_INBUF_EN
                if (io.Clear_FGI) begin
                    if (hold_valid_q) begin
                        inpr_d       = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (in_accept) begin
                        inpr_d = io.Dev_In_Data;
                    end else begin
                        in_state_d = IN_EMPTY;
                    end
                end else if (in_accept) begin
                    hold_d       = io.Dev_In_Data;
                    hold_valid_d = 1'b1;
                end
`else
                if (io.Clear_FGI) begin
                    in_state_d = IN_EMPTY;
                end
`endif
            end
            default: in_state_d = IN_EMPTY;
        endcase
    end

    always_comb begin
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        case (out_state_q)
            OUT_IDLE: begin
                if (io.LD_OUTR) begin
                    out_data_d  = io.OUTR_In;
                    out_state_d = OUT_SEND;
                end
            end
            OUT_SEND: begin
                // A load while busy is dropped; only the error flag records it.
                if (io.LD_OUTR) begin
                    out_err_d = 1'b1;
                end
                if (io.Dev_Out_Ready) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
        irq_d = io.IEN && (fgi || fgo);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            in_state_q  <= IN_EMPTY;
            inpr_q      <= 8'h00;
            out_state_q <= OUT_IDLE;
            out_data_q  <= 8'h00;
            out_err_q   <= 1'b0;
            irq_q       <= 1'b0;
`ifdef IO_INBUF_EN
            hold_valid_q <= 1'b0;
            hold_q       <= 8'h00;
`endif
        end else begin
            in_state_q  <= in_state_d;
            inpr_q      <= inpr_d;
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            irq_q       <= irq_d;
`ifdef IO_INBUF_EN
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
`endif
        end
    end

    assign io.INPR          = inpr_q;
    assign io.FGI           = fgi;
    assign io.FGO           = fgo;
    assign io.Dev_Out_Valid = (out_state_q == OUT_SEND);
    assign io.Dev_Out_Data  = out_data_q;
    assign io.Out_Err       = out_err_q;
    assign io.IRQ           = irq_q;
    assign io.in_state_dbg  = in_state_q;
    assign io.out_state_dbg = out_state_q;
endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed flag/handshake checks plus
// scoreboarded input and output character streams.
module tb_io_controller;
  logic clk;
  logic rst_n;
  io_controller_if bus ();

  io_controller dut (
    .Clk   (clk),
    .Reset (rst_n),
    .io    (bus)
  );

  int total = 0;
  int bad = 0;
  int vld_cycles = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: characters leaving through either side are compared in order
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && bus.Dev_Out_Valid) vld_cycles++;
    if (rst_n && bus.Dev_Out_Valid && bus.Dev_Out_Ready) begin
      if (out_q.size() == 0) check("out_q_nonempty", out_q.size(), 32'd1);
      else begin
        e = out_q.pop_front();
        check("out_data", bus.Dev_Out_Data, e);
      end
    end
    if (rst_n && bus.FGI && bus.Clear_FGI) begin
      if (in_q.size() == 0) check("in_q_nonempty", in_q.size(), 32'd1);
      else begin
        e = in_q.pop_front();
        check("inpr_data", bus.INPR, e);
      end
    end
  end

  // driver tasks
  task automatic in_char(input logic [7:0] d);
    bus.Dev_In_Valid = 1'b1;
    bus.Dev_In_Data  = d;
    in_q.push_back(d);
    tick();
    bus.Dev_In_Valid = 1'b0;
  endtask

  task automatic clear_fgi();
    bus.Clear_FGI = 1'b1;
    tick();
    bus.Clear_FGI = 1'b0;
  endtask

  task automatic load_out(input logic [7:0] d);
    bus.LD_OUTR = 1'b1;
    bus.OUTR_In = d;
    out_q.push_back(d);
    tick();
    bus.LD_OUTR = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    bus.Dev_In_Valid = 1'b0;
    bus.Dev_In_Data = 8'h00;
    bus.Dev_Out_Ready = 1'b0;
    bus.OUTR_In = 8'h00;
    bus.LD_OUTR = 1'b0;
    bus.Clear_FGI = 1'b0;
    bus.IEN = 1'b0;
    repeat (3) tick();

    check("rst_fgi", bus.FGI, 1'b0);
    check("rst_fgo", bus.FGO, 1'b1);
    check("rst_inpr", bus.INPR, 8'h00);
    check("rst_out_valid", bus.Dev_Out_Valid, 1'b0);
    check("rst_out_data", bus.Dev_Out_Data, 8'h00);
    check("rst_err", bus.Out_Err, 1'b0);
    check("rst_irq", bus.IRQ, 1'b0);
    check("rst_in_ready", bus.Dev_In_Ready, 1'b0);

    // interrupt from FGO right after reset release, then disable
    bus.IEN = 1'b1;
    rst_n = 1'b1;
    tick();
    check("irq_after_release", bus.IRQ, 1'b1);
    check("in_ready_idle", bus.Dev_In_Ready, 1'b1);
    bus.IEN = 1'b0;
    tick();
    check("irq_ien_off", bus.IRQ, 1'b0);

    // input character and flag clear
    in_char(8'h41);
    check("in_inpr_41", bus.INPR, 8'h41);
    check("in_fgi_set", bus.FGI, 1'b1);
`ifndef IO_INBUF_EN
    check("in_ready_full", bus.Dev_In_Ready, 1'b0);
`endif
    clear_fgi();
    check("in_fgi_clr", bus.FGI, 1'b0);
    check("in_ready_again", bus.Dev_In_Ready, 1'b1);
    check("inpr_hold", bus.INPR, 8'h41);
    clear_fgi();
    check("clr_ignored_fgi", bus.FGI, 1'b0);
    check("clr_ignored_inpr", bus.INPR, 8'h41);

    // output with 5 stall cycles, plus a rejected load while busy
    vld_cycles = 0;
    load_out(8'h5A);
    check("out_valid", bus.Dev_Out_Valid, 1'b1);
    check("out_fgo_low", bus.FGO, 1'b0);
    check("err_before", bus.Out_Err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.LD_OUTR = 1'b1;
        bus.OUTR_In = 8'h33;
      end
      tick();
      bus.LD_OUTR = 1'b0;
      check("out_stall_valid", bus.Dev_Out_Valid, 1'b1);
      check("out_stall_data", bus.Dev_Out_Data, 8'h5A);
    end
    check("err_set", bus.Out_Err, 1'b1);
    bus.Dev_Out_Ready = 1'b1;
    tick();
    bus.Dev_Out_Ready = 1'b0;
    check("out_done_valid", bus.Dev_Out_Valid, 1'b0);
    check("out_done_fgo", bus.FGO, 1'b1);
    check("out_valid_cycles", vld_cycles, 32'd6);

    // IRQ tracks FGI|FGO with one cycle lag
    bus.IEN = 1'b1;
    load_out(8'hC3);
    tick();
    check("irq_both_low", bus.IRQ, 1'b0);
    in_char(8'h9E);
    tick();
    check("irq_fgi", bus.IRQ, 1'b1);
    check("err_sticky", bus.Out_Err, 1'b1);

    // simultaneous clear + output transfer, then simultaneous load + input accept
    bus.Clear_FGI = 1'b1;
    bus.Dev_Out_Ready = 1'b1;
    tick();
    bus.Clear_FGI = 1'b0;
    bus.Dev_Out_Ready = 1'b0;
    check("sim_fgi", bus.FGI, 1'b0);
    check("sim_fgo", bus.FGO, 1'b1);
    bus.LD_OUTR = 1'b1;
    bus.OUTR_In = 8'h7E;
    out_q.push_back(8'h7E);
    in_char(8'h11);
    bus.LD_OUTR = 1'b0;
    check("sim2_inpr", bus.INPR, 8'h11);
    check("sim2_out_data", bus.Dev_Out_Data, 8'h7E);
    check("sim2_fgo", bus.FGO, 1'b0);

    // reset in the middle of both transfers abandons them
    rst_n = 1'b0;
    tick();
    in_q.delete();
    out_q.delete();
    check("mid_rst_fgo", bus.FGO, 1'b1);
    check("mid_rst_fgi", bus.FGI, 1'b0);
    check("mid_rst_valid", bus.Dev_Out_Valid, 1'b0);
    check("mid_rst_inpr", bus.INPR, 8'h00);
    check("mid_rst_out_data", bus.Dev_Out_Data, 8'h00);
    check("mid_rst_err", bus.Out_Err, 1'b0);
    check("mid_rst_irq", bus.IRQ, 1'b0);
    bus.IEN = 1'b0;
    rst_n = 1'b1;
    tick();

    // random character streams
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      in_char(d);
      repeat ($urandom_range(0, 2)) tick();
      clear_fgi();
      d = 8'($urandom_range(0, 255));
      load_out(d);
      repeat ($urandom_range(0, 3)) tick();
      bus.Dev_Out_Ready = 1'b1;
      tick();
      bus.Dev_Out_Ready = 1'b0;
    end
    check("rand_err_clear", bus.Out_Err, 1'b0);

`ifdef IO_INBUF_EN
    // two-entry input buffer keeps order through clears
    in_char(8'h01);
    in_char(8'h02);
    check("buf_ready_full", bus.Dev_In_Ready, 1'b0);
    clear_fgi();
    check("buf_inpr_02", bus.INPR, 8'h02);
    check("buf_fgi_kept", bus.FGI, 1'b1);
    in_char(8'h03);
    clear_fgi();
    check("buf_inpr_03", bus.INPR, 8'h03);
    clear_fgi();
    check("buf_fgi_clr", bus.FGI, 1'b0);
`endif

    tick();
    check("in_q_drained", in_q.size(), 32'd0);
    check("out_q_drained", out_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
